// File: rtl/string_matcher_multi_if.sv
// Bus bundle for string_matcher_multi.
//   clear          flush stream history and match state (patterns kept)
//   data_in/valid  stream word in, byte [7:0] earliest
//   cfg_*          pattern slot write port, cfg_err flags a rejected write
//   data_out/valid delayed stream word leaving the history buffer
//   match*         any-slot flag, per-slot flags, lowest hit slot, hit count
// The master drives stream and configuration; the slave (the matcher) answers.
interface string_matcher_multi_if #(
  parameter int BYTES  = 4,
  parameter int MAXLEN = 17,
  parameter int NPAT   = 4,
  parameter int IW     = (NPAT > 1) ? $clog2(NPAT) : 1,
  parameter int LW     = $clog2(MAXLEN + 1)
);
  logic                clear;
  logic [8*BYTES-1:0]  data_in;
  logic                data_valid;
  logic                cfg_we;
  logic [IW-1:0]       cfg_idx;
  logic [8*MAXLEN-1:0] cfg_string;
  logic [LW-1:0]       cfg_len;
  logic                cfg_err;
  logic [8*BYTES-1:0]  data_out;
  logic                data_out_valid;
  logic                match;
  logic [NPAT-1:0]     match_mask;
  logic [IW-1:0]       match_id;
  logic [15:0]         match_count;

  modport master (
    output clear, data_in, data_valid, cfg_we, cfg_idx, cfg_string, cfg_len,
    input  cfg_err, data_out, data_out_valid, match, match_mask, match_id, match_count
  );

  modport slave (
    input  clear, data_in, data_valid, cfg_we, cfg_idx, cfg_string, cfg_len,
    output cfg_err, data_out, data_out_valid, match, match_mask, match_id, match_count
  );
endinterface

// File: rtl/string_matcher_multi.sv
// Multi-pattern streaming string matcher.
// A DEPTH-word shift history holds the most recent stream bytes. Every accepted
// word is checked against NPAT programmable patterns at every byte alignment of
// the newest word; results are registered one cycle after the word is accepted.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (clears patterns too)
//   bus   string_matcher_multi_if.slave (stream, config, match results)
module string_matcher_multi #(
  parameter int BYTES  = 4,
  parameter int MAXLEN = 17,
  parameter int NPAT   = 4,
  parameter int STICKY = 1
) (
  input logic                   clk,
  input logic                   rst,
  string_matcher_multi_if.slave bus
);
  localparam int DEPTH = (MAXLEN + 2*BYTES - 2) / BYTES;
  localparam int NB    = DEPTH * BYTES;
  localparam int IW    = (NPAT > 1) ? $clog2(NPAT) : 1;
  localparam int LW    = $clog2(MAXLEN + 1);
  localparam int PW    = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int FW    = $clog2(NB + 1);

  // win[NB-1] is the newest stream byte, win[0] the oldest
  logic [NB-1:0][7:0]               win, win_nx;
  logic [FW-1:0]                    fill;
  int                               fill_nx;
  logic [NPAT-1:0][MAXLEN-1:0][7:0] pat;
  logic [NPAT-1:0][LW-1:0]          plen;
  logic [NPAT-1:0]                  hit;
  logic [IW-1:0]                    hit_id;
  logic                             cfg_bad;
  logic [NPAT-1:0]                  mask_q;
  logic [IW-1:0]                    id_q;
  logic [15:0]                      cnt_q;
  logic [8*BYTES-1:0]               dout_q;
  logic                             dov_q, err_q;

  // Matching looks at the buffer as it will be after this word shifts in
  assign win_nx  = {bus.data_in, win[NB-1:BYTES]};
  assign fill_nx = (int'(fill) + BYTES > NB) ? NB : int'(fill) + BYTES;
  assign cfg_bad = (int'(bus.cfg_len) > MAXLEN) || (int'(bus.cfg_idx) >= NPAT);

  for (genvar k = 0; k < NPAT; k++) begin : g_slot
    logic [BYTES-1:0] align_ok;
    for (genvar a = 0; a < BYTES; a++) begin : g_align
      logic [MAXLEN-1:0] byte_ok;
      // Walk backwards from the alignment end: window byte (end-j) against
      // pattern byte (len-1-j). Bytes past the pattern length always pass.
      for (genvar j = 0; j < MAXLEN; j++) begin : g_byte
        logic [PW-1:0] pidx;
        assign pidx       = PW'(plen[k] - LW'(j + 1));
        assign byte_ok[j] = (plen[k] <= LW'(j)) || (win_nx[NB-BYTES+a-j] == pat[k][pidx]);
      end
      // Every compared byte must have actually been received since rst/clear
      assign align_ok[a] = (plen[k] != '0) && (fill_nx >= int'(plen[k]) + (BYTES - 1 - a))
                           && (&byte_ok);
    end
    assign hit[k] = |align_ok;
  end

  always_comb begin
    hit_id = '0;
    for (int k = NPAT - 1; k >= 0; k--)
      if (hit[k]) hit_id = IW'(k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win    <= '0;
      fill   <= '0;
      plen   <= '0;
      dout_q <= '0;
      dov_q  <= 1'b0;
      mask_q <= '0;
      id_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= bus.cfg_we && cfg_bad && !bus.clear;
      if (bus.cfg_we && !cfg_bad) begin
        plen[bus.cfg_idx] <= bus.cfg_len;
        pat[bus.cfg_idx]  <= bus.cfg_string;
      end
      if (bus.clear) begin
        win    <= '0;
        fill   <= '0;
        dout_q <= '0;
        dov_q  <= 1'b0;
        mask_q <= '0;
        id_q   <= '0;
        cnt_q  <= '0;
      end else if (bus.data_valid) begin
        win    <= win_nx;
        fill   <= FW'(fill_nx);
        dout_q <= win[BYTES-1:0];
        // The exiting word is real only once the whole history has been filled
        dov_q  <= (int'(fill) == NB);
        mask_q <= (STICKY != 0) ? (mask_q | hit) : hit;
        if (|hit) begin
          id_q <= hit_id;
          if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
      end else begin
        dov_q <= 1'b0;
        if (STICKY == 0) mask_q <= '0;
      end
    end
  end

  assign bus.cfg_err        = err_q;
  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = dov_q;
  assign bus.match          = |mask_q;
  assign bus.match_mask     = mask_q;
  assign bus.match_id       = id_q;
  assign bus.match_count    = cnt_q;
endmodule
